// File: rtl/spi_tx_shift_register.sv
// spi_tx_shift_register: parallel-in / serial-out shifter for the SPI TX path.
// A WIDTH-bit word is taken over a valid/ready handshake and then shifted out
// one bit per io_enable strobe on the registered io_out line. io_done pulses
// for one cycle after the last bit has been consumed.
// Build option: define SPI_TX_LSB_FIRST_EN to transmit LSB first (shift right);
// by default the word is sent MSB first (shift left).
module spi_tx_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_load_valid,
    input  logic [WIDTH-1:0] io_load_data,
    output logic             io_load_ready,
    input  logic             io_enable,
    output logic             io_out,
    output logic             io_busy,
    output logic             io_done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             done_q, done_d;

    // Advance the word by one bit position in the transmit direction.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
`ifdef SPI_TX_LSB_FIRST_EN
        return {1'b0, w[WIDTH-1:1]};
`else
        return {w[WIDTH-2:0], 1'b0};
`endif
    endfunction

    // The bit of a word that is currently presented on the serial line.
    function automatic logic line_bit(input logic [WIDTH-1:0] w);
`ifdef SPI_TX_LSB_FIRST_EN
        return w[0];
`else
        return w[WIDTH-1];
`endif
    endfunction

    // Ready is a pure function of the state so upstream sees it without delay.
    assign io_load_ready = (state_q == ST_IDLE);
    assign io_busy       = (state_q == ST_SHIFT);
    assign io_out        = out_q;
    assign io_done       = done_q;

    // State register with synchronous, high-priority reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load in IDLE, shift/terminate on strobes in SHIFT.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_load_valid) begin
                    state_d = ST_SHIFT;
                    shreg_d = io_load_data;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    out_d   = line_bit(io_load_data);
                end else begin
                    // io_enable has no effect while idle; line rests low.
                    out_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (io_enable) begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        shreg_d = shift_word(shreg_q);
                        cnt_d   = cnt_q - CNT_W'(1);
                        out_d   = line_bit(shreg_d);
                    end else begin
                        // Final bit consumed: return to idle and flag completion.
                        state_d = ST_IDLE;
                        shreg_d = {WIDTH{1'b0}};
                        out_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    // No strobe: everything holds, io_out stays stable.
                    out_d = out_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = {WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                out_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_tx_shift_register.sv
// Self-checking bench for spi_tx_shift_register (WIDTH=8). Table-driven
// vectors cover the basic frame, strobe gaps and load attempts mid-frame;
// hand-written sequences cover reset mid-frame and back-to-back frames.
module tb_spi_tx_shift_register;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_load_valid = 1'b0;
    logic [7:0] io_load_data = 8'h00;
    logic       io_load_ready;
    logic       io_enable = 1'b0;
    logic       io_out;
    logic       io_busy;
    logic       io_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       en;
        logic       e_out;
        logic       e_busy;
        logic       e_ready;
        logic       e_done;
    } vec_t;

    vec_t tbl[$];

    spi_tx_shift_register #(.WIDTH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_load_valid (io_load_valid),
        .io_load_data  (io_load_data),
        .io_load_ready (io_load_ready),
        .io_enable     (io_enable),
        .io_out        (io_out),
        .io_busy       (io_busy),
        .io_done       (io_done)
    );

    always #5 clock = ~clock;

    // k-th transmitted bit of a word (k=0 is the first bit on the line).
    function automatic logic tx(input logic [7:0] w, input int k);
`ifdef SPI_TX_LSB_FIRST_EN
        return w[k];
`else
        return w[7-k];
`endif
    endfunction

    task automatic add(input logic rst, input logic vld, input logic [7:0] data,
                       input logic en, input logic eo, input logic eb,
                       input logic er, input logic ed);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data; v.en = en;
        v.e_out = eo; v.e_busy = eb; v.e_ready = er; v.e_done = ed;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic eo, input logic eb,
                           input logic er, input logic ed);
        chk("io_out", idx, io_out, eo);
        chk("io_busy", idx, io_busy, eb);
        chk("io_load_ready", idx, io_load_ready, er);
        chk("io_done", idx, io_done, ed);
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic rst, input logic vld, input logic [7:0] data, input logic en);
        reset = rst; io_load_valid = vld; io_load_data = data; io_enable = en;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);

        // Frame 1: load 0xC4, enable held high.
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 8'hC4, 1'b1, tx(8'hC4, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b0, 1'b0, 8'h00, 1'b1, tx(8'hC4, k), 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Frame 2: 0xC4 with enable alternating, each bit held two cycles.
        add(1'b0, 1'b1, 8'hC4, 1'b0, tx(8'hC4, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            add(1'b0, 1'b0, 8'h00, 1'b0, tx(8'hC4, k-1), 1'b1, 1'b0, 1'b0);
            add(1'b0, 1'b0, 8'h00, 1'b1, tx(8'hC4, k), 1'b1, 1'b0, 1'b0);
        end
        add(1'b0, 1'b0, 8'h00, 1'b0, tx(8'hC4, 7), 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Frame 3: 0x55 offered during a 0xC4 frame is ignored until ready.
        add(1'b0, 1'b1, 8'hC4, 1'b1, tx(8'hC4, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b0, 1'b1, 8'h55, 1'b1, tx(8'hC4, k), 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b1, 8'h55, 1'b1, tx(8'h55, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) add(1'b0, 1'b0, 8'h00, 1'b1, tx(8'h55, k), 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].en);
            chk_all(i, tbl[i].e_out, tbl[i].e_busy, tbl[i].e_ready, tbl[i].e_done);
        end

        // Reset mid-frame: 0xFF aborted after three strobes, no done pulse.
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        chk_all(100, tx(8'hFF, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk_all(101, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all(102, 1'b0, 1'b0, 1'b1, 1'b0);
        // Reset together with a valid word: the word is dropped.
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk_all(103, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h3C, 1'b1);
        chk_all(104, tx(8'h3C, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk_all(104 + k, tx(8'h3C, k), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all(112, 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back: valid held, 0x0F accepted in the io_done cycle.
        step(1'b0, 1'b1, 8'hA0, 1'b1);
        chk_all(200, tx(8'hA0, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step(1'b0, 1'b1, 8'h0F, 1'b1);
            chk_all(200 + k, tx(8'hA0, k), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 8'h0F, 1'b1);
        chk_all(208, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h0F, 1'b1);
        chk_all(209, tx(8'h0F, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk_all(209 + k, tx(8'h0F, k), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all(217, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk_all(218, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
